// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable clock divider and tick generator
//
// Purpose:
//   Divides clk by 2N, where N is the half-period held in div_active.
//   N can be reprogrammed at run time through a load/ack handshake. The new
//   value is applied only at a terminal count, so the running half-period
//   always completes and no runt pulse is produced. While en is low, a
//   pending divisor is applied on the next edge instead.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   en         in   count enable; counter and clk_div hold when low
//   div_in     in   [WIDTH] requested half-period N (0 is clamped to 1)
//   div_load   in   capture request for div_in
//   div_busy   out  captured divisor waiting to be applied
//   div_ack    out  one-cycle pulse when the new divisor takes effect
//   clk_div    out  divided clock, period 2N, 50% duty
//   tick       out  one-cycle strobe on each clk_div toggle
//   count_out  out  [WIDTH] current half-period counter
//   tick_cnt   out  [16] free-running tick counter (CLKDIV_TICK_CNT_EN only)
//
// Optional feature macro: CLKDIV_TICK_CNT_EN

module clk_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_ack,
  output logic             clk_div,
  output logic             tick,
`ifdef CLKDIV_TICK_CNT_EN
  output logic [15:0]      tick_cnt,
`endif
  output logic [WIDTH-1:0] count_out
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q,      count_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] div_shadow_q, div_shadow_d;
  logic             clk_div_q,    clk_div_d;
  logic             tick_q,       tick_d;
  logic             pending_q,    pending_d;
  logic             div_ack_q,    div_ack_d;
  logic             terminal;

`ifdef CLKDIV_TICK_CNT_EN
  logic [15:0]      tick_cnt_q,   tick_cnt_d;
`endif

  // div_active is never 0, so the subtraction cannot wrap.
  assign terminal = (count_q == (div_active_q - ONE));

  always_comb begin
    count_d      = count_q;
    div_active_d = div_active_q;
    div_shadow_d = div_shadow_q;
    clk_div_d    = clk_div_q;
    tick_d       = 1'b0;
    pending_d    = pending_q;
    div_ack_d    = 1'b0;

    if (en) begin
      if (terminal) begin
        count_d   = '0;
        clk_div_d = ~clk_div_q;
        tick_d    = 1'b1;
        // Swap divisors only at the half-period boundary.
        if (pending_q) begin
          div_active_d = div_shadow_q;
          pending_d    = 1'b0;
          div_ack_d    = 1'b1;
        end
      end else begin
        count_d = count_q + ONE;
      end
    end else if (pending_q) begin
      // Halted: apply immediately and restart the half-period; level holds.
      div_active_d = div_shadow_q;
      count_d      = '0;
      pending_d    = 1'b0;
      div_ack_d    = 1'b1;
    end

    // Capture uses the registered pending flag, so a load on the apply
    // edge (or any load while busy) is dropped.
    if (div_load && !pending_q) begin
      div_shadow_d = (div_in == '0) ? ONE : div_in;
      pending_d    = 1'b1;
    end
  end

`ifdef CLKDIV_TICK_CNT_EN
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_d) tick_cnt_d = tick_cnt_q + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      div_active_q <= DIV_RST;
      div_shadow_q <= DIV_RST;
      clk_div_q    <= 1'b0;
      tick_q       <= 1'b0;
      pending_q    <= 1'b0;
      div_ack_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      div_active_q <= div_active_d;
      div_shadow_q <= div_shadow_d;
      clk_div_q    <= clk_div_d;
      tick_q       <= tick_d;
      pending_q    <= pending_d;
      div_ack_q    <= div_ack_d;
    end
  end

`ifdef CLKDIV_TICK_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end
  assign tick_cnt = tick_cnt_q;
`endif

  assign count_out = count_q;
  assign clk_div   = clk_div_q;
  assign tick      = tick_q;
  assign div_busy  = pending_q;
  assign div_ack   = div_ack_q;

endmodule
